alu_issue_stage: RTL and testbench

- ID/EX-boundary producer of the 32-bit ALU's 4-bit operation code and operands.
- Decodes the MIPS instruction word and selects operand A/B values, including shift amounts, immediates and the sign-extend/count/rotate selector encodings on B.
- Registers the results into the EX-stage pipeline register with valid/stall/flush handling.
- Inserts a fixed multi-cycle hold when MUL enters EX.

---
 rtl/alu_issue_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Decodes MIPS instruction words into ALU op code and operands
//               and registers them into the EX-stage pipeline register, with
//               stall, flush and multi-cycle MUL occupancy handling.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int BITS_SIZE  = 32,
    parameter int ALU_SIZE   = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    input  logic [BITS_SIZE-1:0] id_rs_data,
    input  logic [BITS_SIZE-1:0] id_rt_data,
    input  logic                 ex_stall,
    input  logic                 flush,
    output logic                 id_ready,
    output logic                 ex_valid,
    output logic [ALU_SIZE-1:0]  ex_alu_control,
    output logic [BITS_SIZE-1:0] ex_alu_a,
    output logic [BITS_SIZE-1:0] ex_alu_b,
    output logic                 ex_illegal,
    output logic                 ex_cmp_invert
);

    // ALU operation codes
    localparam logic [ALU_SIZE-1:0] c_alu_and  = ALU_SIZE'(0);
    localparam logic [ALU_SIZE-1:0] c_alu_or   = ALU_SIZE'(1);
    localparam logic [ALU_SIZE-1:0] c_alu_add  = ALU_SIZE'(2);
    localparam logic [ALU_SIZE-1:0] c_alu_nor  = ALU_SIZE'(3);
    localparam logic [ALU_SIZE-1:0] c_alu_xor  = ALU_SIZE'(4);
    localparam logic [ALU_SIZE-1:0] c_alu_sext = ALU_SIZE'(5);
    localparam logic [ALU_SIZE-1:0] c_alu_sub  = ALU_SIZE'(6);
    localparam logic [ALU_SIZE-1:0] c_alu_slt  = ALU_SIZE'(7);
    localparam logic [ALU_SIZE-1:0] c_alu_mul  = ALU_SIZE'(9);
    localparam logic [ALU_SIZE-1:0] c_alu_sll  = ALU_SIZE'(10);
    localparam logic [ALU_SIZE-1:0] c_alu_sgt  = ALU_SIZE'(11);
    localparam logic [ALU_SIZE-1:0] c_alu_clx  = ALU_SIZE'(12);
    localparam logic [ALU_SIZE-1:0] c_alu_srx  = ALU_SIZE'(13);
    localparam logic [ALU_SIZE-1:0] c_alu_sltu = ALU_SIZE'(14);
    localparam logic [ALU_SIZE-1:0] c_alu_sra  = ALU_SIZE'(15);

    // Primary opcodes
    localparam logic [5:0] c_op_special  = 6'h00;
    localparam logic [5:0] c_op_beq      = 6'h04;
    localparam logic [5:0] c_op_bne      = 6'h05;
    localparam logic [5:0] c_op_blez     = 6'h06;
    localparam logic [5:0] c_op_bgtz     = 6'h07;
    localparam logic [5:0] c_op_addi     = 6'h08;
    localparam logic [5:0] c_op_addiu    = 6'h09;
    localparam logic [5:0] c_op_slti     = 6'h0A;
    localparam logic [5:0] c_op_sltiu    = 6'h0B;
    localparam logic [5:0] c_op_andi     = 6'h0C;
    localparam logic [5:0] c_op_ori      = 6'h0D;
    localparam logic [5:0] c_op_xori     = 6'h0E;
    localparam logic [5:0] c_op_lui      = 6'h0F;
    localparam logic [5:0] c_op_special2 = 6'h1C;
    localparam logic [5:0] c_op_special3 = 6'h1F;
    localparam logic [5:0] c_op_lw       = 6'h23;
    localparam logic [5:0] c_op_sw       = 6'h2B;

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_mul_reload = CNT_W'(MUL_CYCLES - 1);

    localparam logic [BITS_SIZE-1:0] c_zero = '0;
    localparam logic [BITS_SIZE-1:0] c_one  = BITS_SIZE'(1);
    localparam logic [BITS_SIZE-1:0] c_lui_shift = BITS_SIZE'(16);

    logic [5:0]           w_op;
    logic [5:0]           w_funct;
    logic [4:0]           w_sa;
    logic [15:0]          w_imm;
    logic [BITS_SIZE-1:0] w_se;
    logic [BITS_SIZE-1:0] w_ze;
    logic [BITS_SIZE-1:0] w_sa_ext;
    logic [BITS_SIZE-1:0] w_rs_shamt;
    logic [BITS_SIZE-1:0] w_srl_b;
    logic [BITS_SIZE-1:0] w_srlv_b;

    logic [ALU_SIZE-1:0]  w_ctrl;
    logic [BITS_SIZE-1:0] w_a;
    logic [BITS_SIZE-1:0] w_b;
    logic                 w_illegal;
    logic                 w_invert;
    logic                 w_is_mul;

    logic                 r_valid;
    logic [ALU_SIZE-1:0]  r_ctrl;
    logic [BITS_SIZE-1:0] r_a;
    logic [BITS_SIZE-1:0] r_b;
    logic                 r_illegal;
    logic                 r_invert;
    logic [CNT_W-1:0]     r_mul_cnt;

    // The rt register index is consumed by the register file, not here
    logic unused_rt_field;
    assign unused_rt_field = ^id_instr[20:16];

    assign w_op       = id_instr[31:26];
    assign w_funct    = id_instr[5:0];
    assign w_sa       = id_instr[10:6];
    assign w_imm      = id_instr[15:0];
    assign w_se       = {{(BITS_SIZE-16){w_imm[15]}}, w_imm};
    assign w_ze       = {{(BITS_SIZE-16){1'b0}}, w_imm};
    assign w_sa_ext   = {{(BITS_SIZE-5){1'b0}}, w_sa};
    assign w_rs_shamt = {{(BITS_SIZE-5){1'b0}}, id_rs_data[4:0]};
    // Bit 5 of the shift operand selects rotate instead of logical shift
    assign w_srl_b    = {{(BITS_SIZE-6){1'b0}}, id_instr[21], w_sa};
    assign w_srlv_b   = {{(BITS_SIZE-6){1'b0}}, id_instr[6], id_rs_data[4:0]};

    always_comb begin
        w_ctrl    = c_alu_and;
        w_a       = c_zero;
        w_b       = c_zero;
        w_illegal = 1'b0;
        w_invert  = 1'b0;
        w_is_mul  = 1'b0;
        case (w_op)
            c_op_special: begin
                case (w_funct)
                    6'h20, 6'h21: begin w_ctrl = c_alu_add;  w_a = id_rs_data; w_b = id_rt_data; end
                    6'h22, 6'h23: begin w_ctrl = c_alu_sub;  w_a = id_rs_data; w_b = id_rt_data; end
                    6'h24:        begin w_ctrl = c_alu_and;  w_a = id_rs_data; w_b = id_rt_data; end
                    6'h25:        begin w_ctrl = c_alu_or;   w_a = id_rs_data; w_b = id_rt_data; end
                    6'h26:        begin w_ctrl = c_alu_xor;  w_a = id_rs_data; w_b = id_rt_data; end
                    6'h27:        begin w_ctrl = c_alu_nor;  w_a = id_rs_data; w_b = id_rt_data; end
                    6'h2A:        begin w_ctrl = c_alu_slt;  w_a = id_rs_data; w_b = id_rt_data; end
                    6'h2B:        begin w_ctrl = c_alu_sltu; w_a = id_rs_data; w_b = id_rt_data; end
                    6'h00:        begin w_ctrl = c_alu_sll;  w_a = id_rt_data; w_b = w_sa_ext;   end
                    6'h04:        begin w_ctrl = c_alu_sll;  w_a = id_rt_data; w_b = w_rs_shamt; end
                    6'h02:        begin w_ctrl = c_alu_srx;  w_a = id_rt_data; w_b = w_srl_b;    end
                    6'h06:        begin w_ctrl = c_alu_srx;  w_a = id_rt_data; w_b = w_srlv_b;   end
                    6'h03:        begin w_ctrl = c_alu_sra;  w_a = id_rt_data; w_b = w_sa_ext;   end
                    6'h07:        begin w_ctrl = c_alu_sra;  w_a = id_rt_data; w_b = w_rs_shamt; end
                    default:      w_illegal = 1'b1;
                endcase
            end
            c_op_special2: begin
                case (w_funct)
                    6'h02: begin
                        w_ctrl   = c_alu_mul;
                        w_a      = id_rs_data;
                        w_b      = id_rt_data;
                        w_is_mul = 1'b1;
                    end
                    6'h20:   begin w_ctrl = c_alu_clx; w_a = id_rs_data; w_b = c_one;  end
                    6'h21:   begin w_ctrl = c_alu_clx; w_a = id_rs_data; w_b = c_zero; end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_op_special3: begin
                if (w_funct == 6'h20 && w_sa == 5'h10) begin
                    w_ctrl = c_alu_sext;
                    w_a    = id_rt_data;
                    w_b    = c_zero;
                end else if (w_funct == 6'h20 && w_sa == 5'h18) begin
                    w_ctrl = c_alu_sext;
                    w_a    = id_rt_data;
                    w_b    = c_one;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_op_addi, c_op_addiu, c_op_lw, c_op_sw: begin
                w_ctrl = c_alu_add;  w_a = id_rs_data; w_b = w_se;
            end
            c_op_slti:  begin w_ctrl = c_alu_slt;  w_a = id_rs_data; w_b = w_se; end
            c_op_sltiu: begin w_ctrl = c_alu_sltu; w_a = id_rs_data; w_b = w_se; end
            c_op_andi:  begin w_ctrl = c_alu_and;  w_a = id_rs_data; w_b = w_ze; end
            c_op_ori:   begin w_ctrl = c_alu_or;   w_a = id_rs_data; w_b = w_ze; end
            c_op_xori:  begin w_ctrl = c_alu_xor;  w_a = id_rs_data; w_b = w_ze; end
            c_op_lui:   begin w_ctrl = c_alu_sll;  w_a = w_ze;       w_b = c_lui_shift; end
            c_op_beq, c_op_bne: begin
                w_ctrl = c_alu_sub;  w_a = id_rs_data; w_b = id_rt_data;
            end
            c_op_bgtz:  begin w_ctrl = c_alu_sgt;  w_a = id_rs_data; w_b = c_zero; end
            // BLEZ reuses the greater-than compare with the result inverted
            c_op_blez:  begin
                w_ctrl   = c_alu_sgt;
                w_a      = id_rs_data;
                w_b      = c_zero;
                w_invert = 1'b1;
            end
            default:    w_illegal = 1'b1;
        endcase
    end

    assign id_ready = !Rst && !ex_stall && (r_mul_cnt == '0);

    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_illegal <= 1'b0;
            r_invert  <= 1'b0;
            r_mul_cnt <= '0;
        end else if (!id_ready) begin
            if (r_mul_cnt != '0 && !ex_stall) begin
                r_mul_cnt <= r_mul_cnt - 1'b1;
            end
        end else if (id_valid) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_a       <= w_a;
            r_b       <= w_b;
            r_illegal <= w_illegal;
            r_invert  <= w_invert;
            r_mul_cnt <= w_is_mul ? c_mul_reload : '0;
        end else begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_illegal <= 1'b0;
            r_invert  <= 1'b0;
            r_mul_cnt <= '0;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_alu_control = r_ctrl;
    assign ex_alu_a       = r_a;
    assign ex_alu_b       = r_b;
    assign ex_illegal     = r_illegal;
    assign ex_cmp_invert  = r_invert;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Scoreboard bench for alu_issue_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        Clk;
    logic        Rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        ex_stall;
    logic        flush;
    logic        id_ready;
    logic        ex_valid;
    logic [3:0]  ex_alu_control;
    logic [31:0] ex_alu_a;
    logic [31:0] ex_alu_b;
    logic        ex_illegal;
    logic        ex_cmp_invert;

    alu_issue_stage #(
        .BITS_SIZE  (32),
        .ALU_SIZE   (4),
        .MUL_CYCLES (3)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .ex_stall       (ex_stall),
        .flush          (flush),
        .id_ready       (id_ready),
        .ex_valid       (ex_valid),
        .ex_alu_control (ex_alu_control),
        .ex_alu_a       (ex_alu_a),
        .ex_alu_b       (ex_alu_b),
        .ex_illegal     (ex_illegal),
        .ex_cmp_invert  (ex_cmp_invert)
    );

    typedef struct {
        string       name;
        logic        rdy;
        logic        vld;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
        logic        inv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_LW   = 32'h8C22FFFC;
    localparam logic [31:0] I_SRL  = 32'h00031102;
    localparam logic [31:0] I_ROTR = 32'h00231102;
    localparam logic [31:0] I_LUI  = 32'h3C011234;
    localparam logic [31:0] I_MUL  = 32'h70221802;
    localparam logic [31:0] I_BLEZ = 32'h18200003;
    localparam logic [31:0] I_ILL  = 32'hFC000000;
    localparam logic [31:0] I_SEH  = 32'h7C021E20;
    localparam logic [31:0] I_SLTI = 32'h2822FFFF;
    localparam logic [31:0] I_ORI  = 32'h3422FFFF;
    localparam logic [31:0] RT_SH  = 32'h80000001;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Apply one cycle of inputs and queue the outputs expected during it
    task automatic cyc(input string nm, input logic rst, input logic v,
                       input logic [31:0] instr, input logic [31:0] rs,
                       input logic [31:0] rt, input logic st, input logic fl,
                       input logic e_rdy, input logic e_vld, input logic [3:0] e_ctl,
                       input logic [31:0] e_a, input logic [31:0] e_b,
                       input logic e_ill, input logic e_inv);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst        = rst;
        id_valid   = v;
        id_instr   = instr;
        id_rs_data = rs;
        id_rt_data = rt;
        ex_stall   = st;
        flush      = fl;
        e.name = nm; e.rdy = e_rdy; e.vld = e_vld; e.ctl = e_ctl;
        e.a = e_a; e.b = e_b; e.ill = e_ill; e.inv = e_inv;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (id_ready !== e.rdy || ex_valid !== e.vld || ex_alu_control !== e.ctl ||
                    ex_alu_a !== e.a || ex_alu_b !== e.b || ex_illegal !== e.ill ||
                    ex_cmp_invert !== e.inv) begin
                    n_err++;
                    $display("FAIL %s: got rdy=%b vld=%b ctl=%0d a=%h b=%h ill=%b inv=%b, want rdy=%b vld=%b ctl=%0d a=%h b=%h ill=%b inv=%b",
                             e.name, id_ready, ex_valid, ex_alu_control, ex_alu_a, ex_alu_b,
                             ex_illegal, ex_cmp_invert, e.rdy, e.vld, e.ctl, e.a, e.b, e.ill, e.inv);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        Rst = 1'b1; id_valid = 1'b1; id_instr = I_ADD;
        id_rs_data = 32'd5; id_rt_data = 32'd7; ex_stall = 1'b0; flush = 1'b0;
        //   name        rst  v  instr   rs            rt            st  fl  rdy vld ctl  a             b             ill inv
        cyc("reset0",    1,   1, I_ADD,  32'd5,        32'd7,        0,  0,  0,  0,  0,   32'h0,        32'h0,        0,  0);
        cyc("reset1",    0,   1, I_ADD,  32'd5,        32'd7,        0,  0,  1,  0,  0,   32'h0,        32'h0,        0,  0);
        cyc("add",       0,   1, I_LW,   32'd5,        32'd7,        0,  0,  1,  1,  2,   32'd5,        32'd7,        0,  0);
        cyc("lw",        0,   1, I_SRL,  32'd5,        RT_SH,        0,  0,  1,  1,  2,   32'd5,        32'hFFFFFFFC, 0,  0);
        cyc("srl",       0,   1, I_ROTR, 32'd5,        RT_SH,        0,  0,  1,  1,  13,  RT_SH,        32'h04,       0,  0);
        cyc("rotr",      0,   1, I_LUI,  32'd5,        RT_SH,        0,  0,  1,  1,  13,  RT_SH,        32'h24,       0,  0);
        cyc("lui",       0,   1, I_MUL,  32'd6,        32'd7,        0,  0,  1,  1,  10,  32'h1234,     32'd16,       0,  0);
        cyc("mul_c1",    0,   1, I_ADD,  32'd1,        32'd2,        0,  0,  0,  1,  9,   32'd6,        32'd7,        0,  0);
        cyc("mul_c2",    0,   1, I_ADD,  32'd1,        32'd2,        0,  0,  0,  1,  9,   32'd6,        32'd7,        0,  0);
        cyc("mul_c3",    0,   1, I_ADD,  32'd1,        32'd2,        0,  0,  1,  1,  9,   32'd6,        32'd7,        0,  0);
        cyc("add_after", 0,   1, I_MUL,  32'd3,        32'd4,        0,  0,  1,  1,  2,   32'd1,        32'd2,        0,  0);
        cyc("mul2_c1",   0,   0, I_ADD,  32'd0,        32'd0,        0,  0,  0,  1,  9,   32'd3,        32'd4,        0,  0);
        cyc("mul2_fl",   0,   0, I_ADD,  32'd0,        32'd0,        0,  1,  0,  1,  9,   32'd3,        32'd4,        0,  0);
        cyc("post_fl",   0,   0, I_ADD,  32'd0,        32'd0,        0,  0,  1,  0,  0,   32'h0,        32'h0,        0,  0);
        cyc("bubble",    0,   1, I_ADD,  32'd5,        32'd7,        0,  0,  1,  0,  0,   32'h0,        32'h0,        0,  0);
        cyc("stall0",    0,   1, I_BLEZ, 32'd5,        32'd7,        1,  0,  0,  1,  2,   32'd5,        32'd7,        0,  0);
        cyc("stall1",    0,   1, I_BLEZ, 32'd5,        32'd7,        1,  0,  0,  1,  2,   32'd5,        32'd7,        0,  0);
        cyc("stall2",    0,   1, I_BLEZ, 32'd5,        32'd7,        1,  0,  0,  1,  2,   32'd5,        32'd7,        0,  0);
        cyc("unstall",   0,   1, I_BLEZ, 32'd5,        32'd7,        0,  0,  1,  1,  2,   32'd5,        32'd7,        0,  0);
        cyc("blez",      0,   1, I_ILL,  32'd5,        32'd7,        0,  0,  1,  1,  11,  32'd5,        32'h0,        0,  1);
        cyc("illegal",   0,   1, I_ADD,  32'd5,        32'd7,        0,  0,  1,  1,  0,   32'h0,        32'h0,        1,  0);
        cyc("st_flush",  0,   1, I_ADD,  32'd5,        32'd7,        1,  1,  0,  1,  2,   32'd5,        32'd7,        0,  0);
        cyc("post_stfl", 0,   1, I_MUL,  32'd3,        32'd4,        0,  0,  1,  0,  0,   32'h0,        32'h0,        0,  0);
        cyc("mul_st0",   0,   0, I_ADD,  32'd0,        32'd0,        1,  0,  0,  1,  9,   32'd3,        32'd4,        0,  0);
        cyc("mul_st1",   0,   0, I_ADD,  32'd0,        32'd0,        1,  0,  0,  1,  9,   32'd3,        32'd4,        0,  0);
        cyc("mul_run0",  0,   0, I_ADD,  32'd0,        32'd0,        0,  0,  0,  1,  9,   32'd3,        32'd4,        0,  0);
        cyc("mul_run1",  0,   0, I_ADD,  32'd0,        32'd0,        0,  0,  0,  1,  9,   32'd3,        32'd4,        0,  0);
        cyc("mul_done",  0,   0, I_ADD,  32'd0,        32'd0,        0,  0,  1,  1,  9,   32'd3,        32'd4,        0,  0);
        cyc("pre_seh",   0,   1, I_SEH,  32'd0,        32'hABCD8000, 0,  0,  1,  0,  0,   32'h0,        32'h0,        0,  0);
        cyc("seh",       0,   1, I_SLTI, 32'd5,        32'd7,        0,  0,  1,  1,  5,   32'hABCD8000, 32'h1,        0,  0);
        cyc("slti",      0,   1, I_ORI,  32'd5,        32'd7,        0,  0,  1,  1,  7,   32'd5,        32'hFFFFFFFF, 0,  0);
        cyc("ori",       0,   0, I_ADD,  32'd5,        32'd7,        0,  0,  1,  1,  1,   32'd5,        32'h0000FFFF, 0,  0);
        cyc("late_rst",  1,   0, I_ADD,  32'd5,        32'd7,        0,  0,  0,  0,  0,   32'h0,        32'h0,        0,  0);
        @(negedge Clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
